// File: rtl/in_to_fifo.sv
// Input-side byte mover: 4-phase start/done handshake into a 2-entry holding
// buffer, drained into the shared FIFO. Optional feature macro: DROP_ON_FULL_EN.
module in_to_fifo #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_done,
  input  logic              fifo_busy,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              isFinish,
  output logic [1:0]        buf_level,
  output logic [CNT_W-1:0]  drop_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic {I_IDLE, I_ACK} i_state_t;
  typedef enum logic {W_IDLE, W_GAP} w_state_t;

  i_state_t          i_state;
  w_state_t          w_state;
  logic [DATA_W-1:0] entry0, entry1;
  logic              accept, push, pop, ack;
`ifdef DROP_ON_FULL_EN
  logic              drop;
`endif

  // Handshake: the source raises in_start with in_data valid; we raise
  // in_done once the byte is taken and drop it only after in_start falls.
  always_comb begin
    accept = (i_state == I_IDLE) && enable && in_start;
    push   = accept && (buf_level != 2'd2);
    pop    = (w_state == W_IDLE) && enable && (buf_level != 2'd0)
             && !fifo_busy && !fifo_full;
`ifdef DROP_ON_FULL_EN
    drop   = accept && (buf_level == 2'd2);
    ack    = push || drop;
`else
    ack    = push;
`endif
  end

  assign dbg_state = {i_state, w_state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_state <= I_IDLE;
      in_done <= 1'b0;
    end else begin
      case (i_state)
        I_IDLE: if (ack) begin
          in_done <= 1'b1;
          i_state <= I_ACK;
        end
        I_ACK: if (!in_start) begin
          in_done <= 1'b0;
          i_state <= I_IDLE;
        end
        default: i_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      fifo_we    <= 1'b0;
      fifo_wdata <= '0;
      isFinish   <= 1'b0;
    end else begin
      isFinish <= 1'b0;
      case (w_state)
        W_IDLE: if (pop) begin
          fifo_we    <= 1'b1;
          fifo_wdata <= entry0;
          w_state    <= W_GAP;
        end
        W_GAP: begin
          fifo_we  <= 1'b0;
          isFinish <= (buf_level == 2'd0);
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // entry0 is always the head; a simultaneous push/pop can only occur at level 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0    <= '0;
      entry1    <= '0;
      buf_level <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_level == 2'd0) entry0 <= in_data;
          else                   entry1 <= in_data;
          buf_level <= buf_level + 2'd1;
        end
        2'b01: begin
          entry0    <= entry1;
          buf_level <= buf_level - 2'd1;
        end
        2'b11: entry0 <= in_data;
        default: ;
      endcase
    end
  end

`ifdef DROP_ON_FULL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_count <= '0;
    else if (drop && (drop_count != '1))     drop_count <= drop_count + CNT_W'(1);
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_in_to_fifo.sv
// Bench for in_to_fifo: table-driven single-byte vectors plus hand-written
// multi-cycle sequences; FIFO writes are checked against an expected queue.
module tb_in_to_fifo;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, in_start, fifo_busy, fifo_full;
  logic [DATA_W-1:0] in_data;
  logic              in_done, fifo_we, isFinish;
  logic [DATA_W-1:0] fifo_wdata;
  logic [1:0]        buf_level, dbg_state;
  logic [CNT_W-1:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;
  int write_count = 0;
  logic prev_we = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  in_to_fifo #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_start(in_start),
    .in_data(in_data), .in_done(in_done), .fifo_busy(fifo_busy),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata),
    .isFinish(isFinish), .buf_level(buf_level), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && fifo_we) begin
      write_count++;
      if (prev_we) begin
        n_vec++; n_err++;
        $display("FAIL we_pulse: got 2-cycle fifo_we expected 1-cycle at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: got %0h expected no write at %0t", fifo_wdata, $time);
      end else begin
        check("fifo_wdata", {24'd0, fifo_wdata}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_we = fifo_we;
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [DATA_W-1:0] d, input bit keep);
    int t;
    in_data  = d;
    in_start = 1'b1;
    tick();
    t = 0;
    while (!in_done && t < 50) begin tick(); t++; end
    if (!in_done) fail_now("ack_timeout");
    else if (keep) exp_q.push_back(d);
    in_start = 1'b0;
    tick();
    t = 0;
    while (in_done && t < 50) begin tick(); t++; end
    if (in_done) fail_now("done_fall_timeout");
  endtask

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              full;
    int                hold;
    logic [1:0]        exp_level;
    logic              exp_we;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0;
    int t;
    rst_n = 1'b0; enable = 1'b1; in_start = 1'b0; in_data = '0;
    fifo_busy = 1'b0; fifo_full = 1'b0;
    #2;
    check("rst_in_done",  in_done, 0);
    check("rst_fifo_we",  fifo_we, 0);
    check("rst_wdata",    fifo_wdata, 0);
    check("rst_finish",   isFinish, 0);
    check("rst_level",    buf_level, 0);
    check("rst_drops",    drop_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-I_ACK: outputs clear without a clock edge.
    fifo_full = 1'b1;
    in_data = 8'h5A; in_start = 1'b1;
    tick();
    t = 0;
    while (!in_done && t < 10) begin tick(); t++; end
    check("t1_acked", in_done, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_in_done", in_done, 0);
    check("t1_fifo_we", fifo_we, 0);
    check("t1_finish",  isFinish, 0);
    check("t1_level",   buf_level, 0);
    check("t1_drops",   drop_count, 0);
    in_start = 1'b0;
    tick();
    rst_n = 1'b1; fifo_full = 1'b0;
    tick();

    // Single byte latency: ack after 1 edge, write after the next, finish after that.
    in_data = 8'hA5; in_start = 1'b1;
    tick();
    check("t2_in_done", in_done, 1);
    check("t2_no_we_yet", fifo_we, 0);
    exp_q.push_back(8'hA5);
    in_start = 1'b0;
    tick();
    check("t2_we", fifo_we, 1);
    check("t2_wdata", fifo_wdata, 8'hA5);
    check("t2_no_finish_yet", isFinish, 0);
    tick();
    check("t2_we_low", fifo_we, 0);
    check("t2_finish", isFinish, 1);
    check("t2_level", buf_level, 0);
    tick();
    check("t2_finish_pulse", isFinish, 0);

    // Table: byte held by busy/full for a while, then written on the first free cycle.
    vecs[0] = '{8'h3C, 1'b1, 1'b0, 5, 2'd1, 1'b1};
    vecs[1] = '{8'hC3, 1'b0, 1'b1, 3, 2'd1, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 2, 2'd1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1, 2'd1, 1'b1};
    vecs[4] = '{DATA_W'($urandom_range(0, 255)), 1'b0, 1'b1, 4, 2'd1, 1'b1};
    vecs[5] = '{DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0, 0, 2'd1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      fifo_busy = vecs[i].busy; fifo_full = vecs[i].full;
      w0 = write_count;
      send_byte(vecs[i].data, 1'b1);
      repeat (vecs[i].hold) tick();
      check("vec_hold_no_write", write_count - w0, 0);
      check("vec_hold_level", buf_level, vecs[i].exp_level);
      fifo_busy = 1'b0; fifo_full = 1'b0;
      tick();
      check("vec_write_on_release", fifo_we, vecs[i].exp_we);
      tick();
      check("vec_finish", isFinish, 1);
    end

`ifdef DROP_ON_FULL_EN
    // Overflow with drop enabled: all acked, last two discarded.
    fifo_full = 1'b1;
    w0 = write_count;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("t5_level", buf_level, 2);
    check("t5_drops", drop_count, 2);
    fifo_full = 1'b0;
    repeat (8) tick();
    check("t5_writes", write_count - w0, 2);
    check("t5_drained", exp_q.size(), 0);
`else
    // Back-pressure: third byte withheld until the buffer drains.
    fifo_full = 1'b1;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    in_data = 8'h03; in_start = 1'b1;
    repeat (4) begin
      tick();
      check("t3_withheld", in_done, 0);
    end
    check("t3_level_full", buf_level, 2);
    fifo_full = 1'b0;
    tick();
    check("t3_we_01", fifo_we, 1);
    tick();
    check("t3_gap1", fifo_we, 0);
    check("t3_ack_03", in_done, 1);
    exp_q.push_back(8'h03);
    in_start = 1'b0;
    tick();
    check("t3_we_02", fifo_we, 1);
    tick();
    check("t3_gap2", fifo_we, 0);
    check("t3_no_finish", isFinish, 0);
    tick();
    check("t3_we_03", fifo_we, 1);
    tick();
    check("t3_finish", isFinish, 1);
    check("t3_drops", drop_count, 0);
`endif
    tick();

    // enable low holds a full buffer; re-enable drains it.
    fifo_full = 1'b1;
    send_byte(8'h6B, 1'b1);
    send_byte(8'hB6, 1'b1);
    enable = 1'b0; fifo_full = 1'b0;
    w0 = write_count;
    repeat (5) tick();
    check("t6_no_write", write_count - w0, 0);
    check("t6_level", buf_level, 2);
    enable = 1'b1;
    tick();
    check("t6_we_1", fifo_we, 1);
    tick();
    tick();
    check("t6_we_2", fifo_we, 1);
    tick();
    check("t6_finish", isFinish, 1);
    check("t6_level_end", buf_level, 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
